// File: rtl/cpu6_fetch_buf_pkg.sv
// Shared constants for the cpu6 instruction prefetch buffer.
package cpu6_fetch_buf_pkg;

  localparam int                   CPU6_XLEN      = 32;
  localparam int                   FETCH_DEPTH    = 2;
  localparam logic [CPU6_XLEN-1:0] FETCH_RESET_PC = 32'h0000_0000;

  // Width of a counter able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cpu6_fetch_fifo.sv
// DEPTH x XLEN instruction queue: push/pop/clear, occupancy count, head word.
module cpu6_fetch_fifo
  import cpu6_fetch_buf_pkg::*;
#(
  parameter  int DEPTH = FETCH_DEPTH,
  parameter  int XLEN  = CPU6_XLEN,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = cnt_w(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            push,
  input  logic [XLEN-1:0] wdata,
  input  logic            pop,
  output logic [CW-1:0]   count,
  output logic [XLEN-1:0] head
);

  logic [DEPTH-1:0][XLEN-1:0] mem;
  logic [AW-1:0]              rd_ptr;
  logic [AW-1:0]              wr_ptr;

  assign head = mem[rd_ptr];

  // Storage and pointers; DEPTH is a power of two so pointers wrap naturally.
  // Callers never push when full or pop when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/cpu6_fetch_buf.sv
// Prefetch buffer ahead of the cpu6 fetch port: sequential word fetches,
// in-order response queueing, and redirect with in-flight response discard.
module cpu6_fetch_buf
  import cpu6_fetch_buf_pkg::*;
#(
  parameter int              XLEN     = CPU6_XLEN,
  parameter int              DEPTH    = FETCH_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data
);

  localparam int          CW      = cnt_w(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] redir_tgt;
  logic [CW-1:0]   outst;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outst_after_rsp;
  logic            req_fire;
  logic            rsp;
  logic            keep;
  logic            pop;

  assign redir_tgt = redir_pc & ~XLEN'(3);

  // A stray response with nothing outstanding is ignored so outst cannot underflow.
  assign rsp             = mem_rsp_valid & (outst != '0);
  assign outst_after_rsp = outst - CW'(rsp);

  // Requests are capped so every outstanding response already owns a queue slot.
  assign mem_req_valid = reset & ~redir_valid &
                         (({1'b0, outst} + {1'b0, count}) < DEPTH_C);
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid & mem_req_ready;

  assign out_valid = (count != '0);
  assign out_pc    = head_pc;
  assign pop       = out_valid & out_ready & ~redir_valid;
  assign keep      = rsp & (discard == '0) & ~redir_valid;

  // PC and in-flight bookkeeping; a redirect overrides everything in its cycle
  // and marks every response still in flight as stale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      head_pc  <= RESET_PC;
      outst    <= '0;
      discard  <= '0;
    end else if (redir_valid) begin
      fetch_pc <= redir_tgt;
      head_pc  <= redir_tgt;
      outst    <= outst_after_rsp;
      discard  <= outst_after_rsp;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
      if (pop)      head_pc  <= head_pc + XLEN'(4);
      outst <= outst_after_rsp + CW'(req_fire);
      if (rsp && (discard != '0)) discard <= discard - 1'b1;
    end
  end

  cpu6_fetch_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .clr   (redir_valid),
    .push  (keep),
    .wdata (mem_rsp_data),
    .pop   (pop),
    .count (count),
    .head  (out_instr)
  );

  // Memory must never answer a request that was not made.
  a_rsp_has_req: assert property (@(posedge clk) disable iff (!reset)
                                  mem_rsp_valid |-> (outst != '0));

endmodule
